hsv_core_ctrlstatus_counters: RTL and testbench
===============================================

// Module: hsv_core_ctrlstatus_counters
// PURPOSE
// - CSR bus target behind the ctrlstatus read/write stage: answers its regs_* request/stall/ack bus.
// - Implements mcycle/minstret (+h halves), user aliases cycle/instret (+h) and mcountinhibit.
// - Counts core clocks and retired instructions (retire pulse from commit); one outstanding access.
// PARAMETERS
// - CNT_WIDTH  64  counter width, legal 33..64; bits above CNT_WIDTH read 0, writes ignored
// - HAS_INHIBIT 1  1: mcountinhibit implemented (CY=bit0, IR=bit2); 0: address unmapped, never inhibits
// PORTS
// - clk_core         in   1   core clock
// - rst_core_n       in   1   reset: asynchronous, active-low
// - retire           in   1   one instruction retired this cycle
// - regs_req         in   1   access request
// - regs_req_is_wr   in   1   1 write, 0 read
// - regs_addr        in   16  {csr_num[11:0], 4'b0000}
// - regs_wr_data     in   32  write data
// - regs_wr_biten    in   32  per-bit write enable
// - regs_req_stall_rd out 1   read not accepted this cycle
// - regs_req_stall_wr out 1   write not accepted this cycle
// - regs_rd_ack      out  1   read response pulse
// - regs_rd_err      out  1   read error, valid with rd_ack
// - regs_rd_data     out  32  read data, valid with rd_ack, 0 on error
// - regs_wr_ack      out  1   write response pulse
// - regs_wr_err      out  1   write error, valid with wr_ack
// BEHAVIOUR
// - Reset: mcycle=minstret=0, mcountinhibit=0, all ack/err 0, rd_data 0, stalls 0, FSM IDLE.
// - FSM IDLE->RESP on accept (regs_req & ~stall of matching direction); RESP->IDLE unconditionally.
// - Stalls: both stall outputs =1 in RESP, 0 in IDLE -> max one access per 2 cycles.
// - Latency: response (rd_ack or wr_ack, never both) is a 1-cycle pulse the cycle after accept.
// - Read data sampled at accept cycle (pre-increment value of that edge).
// - Decode: addr[3:0]!=0 or unmapped csr_num -> err=1, no state change.
// - Map: 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi, 0xC00/0xC80/0xC02/0xC82 read-only aliases,
//   0x320 mcountinhibit (HAS_INHIBIT=1; bits other than 0,2 read 0).
// - Write to 0xCxx alias -> wr_err=1, no change.
// - Write merge: new_half = (old_half & ~biten) | (wr_data & biten); applied at accept edge.
// - Counting: mcycle+1 each cycle unless inhibit[0]; minstret+1 when retire & ~inhibit[2].
// - Written counter does not increment on its write edge (write wins, retire pulse lost); untouched half keeps old value.
// - Wrap: all-ones +1 -> 0 across CNT_WIDTH, no sticky flag.
// - mcountinhibit write takes effect from the following edge.
// - Reset mid-access: pending response dropped, no ack after reset release.
// TESTING
// - Reset, idle 10 clk, read 0xB00 -> rd_ack 2nd cycle after req, rd_data=10 +/-1 per fixed sampling rule.
// - Write 0xB80 data 0xFFFFFFFF biten '1, then 0xB00 0xFFFFFFFE -> lo wraps, hi becomes 0 after 2 cycles.
// - retire held 5 cycles with IR inhibit=1 -> minstret unchanged; inhibit cleared, 3 retires -> +3.
// - Write 0xC00 -> wr_ack with wr_err=1; read 0x123 or addr 0xB001 -> rd_err=1, rd_data=0.
// - biten 0x0000FF00, data 0xAABBCCDD to minstret=0x11223344 -> 0x1122CC44.
// - Back-to-back reqs: second req sees stall=1 for exactly 1 cycle, accepted next, acks 2 cycles apart.

Source files
------------

// File: rtl/hsv_core_ctrlstatus_counters.sv
// hsv_core_ctrlstatus_counters
// CSR target for the machine/user cycle and instret counters and mcountinhibit.
// Accepts one access at a time. Every response is a single registered ack pulse
// that appears in the cycle after the request is accepted.
//
// state | meaning
// IDLE  | no access in flight, stalls low, next request is accepted
// RESP  | ack/err/rd_data presented this cycle, stalls high
module hsv_core_ctrlstatus_counters #(
  parameter int unsigned CNT_WIDTH   = 64,
  parameter bit          HAS_INHIBIT = 1'b1
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        retire,
  input  logic        regs_req,
  input  logic        regs_req_is_wr,
  input  logic [15:0] regs_addr,
  input  logic [31:0] regs_wr_data,
  input  logic [31:0] regs_wr_biten,
  output logic        regs_req_stall_rd,
  output logic        regs_req_stall_wr,
  output logic        regs_rd_ack,
  output logic        regs_rd_err,
  output logic [31:0] regs_rd_data,
  output logic        regs_wr_ack,
  output logic        regs_wr_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic                 stall_q;
  logic [CNT_WIDTH-1:0] mcycle_q;
  logic [CNT_WIDTH-1:0] minstret_q;
  logic                 inh_cy_q;
  logic                 inh_ir_q;

  logic        accept;
  logic [11:0] csr_num;
  logic        dec_hit;
  logic        dec_ro;
  logic        sel_cyc;
  logic        sel_ins;
  logic        sel_hi;
  logic        sel_inh;
  logic [31:0] rd_val;
  logic [63:0] mcycle_ext;
  logic [63:0] minstret_ext;
  logic [63:0] cnt_ext;
  logic [31:0] half_old;
  logic [31:0] half_new;
  logic [63:0] wr_ext;
  logic        wr_ok;
  logic        wr_cyc;
  logic        wr_ins;
  logic        wr_inh;

  assign regs_req_stall_rd = stall_q;
  assign regs_req_stall_wr = stall_q;
  assign accept            = regs_req & (state_q == ST_IDLE);

  // Address decode: one-hot selects for counter, half and mcountinhibit.
  always_comb begin
    csr_num = regs_addr[15:4];
    dec_hit = 1'b0;
    dec_ro  = 1'b0;
    sel_cyc = 1'b0;
    sel_ins = 1'b0;
    sel_hi  = 1'b0;
    sel_inh = 1'b0;
    case (csr_num)
      12'hB00: begin dec_hit = 1'b1; sel_cyc = 1'b1; end
      12'hB80: begin dec_hit = 1'b1; sel_cyc = 1'b1; sel_hi = 1'b1; end
      12'hB02: begin dec_hit = 1'b1; sel_ins = 1'b1; end
      12'hB82: begin dec_hit = 1'b1; sel_ins = 1'b1; sel_hi = 1'b1; end
      12'hC00: begin dec_hit = 1'b1; dec_ro = 1'b1; sel_cyc = 1'b1; end
      12'hC80: begin dec_hit = 1'b1; dec_ro = 1'b1; sel_cyc = 1'b1; sel_hi = 1'b1; end
      12'hC02: begin dec_hit = 1'b1; dec_ro = 1'b1; sel_ins = 1'b1; end
      12'hC82: begin dec_hit = 1'b1; dec_ro = 1'b1; sel_ins = 1'b1; sel_hi = 1'b1; end
      12'h320: begin
        if (HAS_INHIBIT) begin
          dec_hit = 1'b1;
          sel_inh = 1'b1;
        end
      end
      default: ;
    endcase
    if (regs_addr[3:0] != 4'h0) dec_hit = 1'b0;
  end

  // Read mux and write merge; counters are zero-extended so bits above CNT_WIDTH read 0.
  always_comb begin
    mcycle_ext   = 64'(mcycle_q);
    minstret_ext = 64'(minstret_q);
    cnt_ext      = sel_cyc ? mcycle_ext : minstret_ext;
    half_old     = sel_hi ? cnt_ext[63:32] : cnt_ext[31:0];
    half_new     = (half_old & ~regs_wr_biten) | (regs_wr_data & regs_wr_biten);
    wr_ext       = sel_hi ? {half_new, cnt_ext[31:0]} : {cnt_ext[63:32], half_new};
    rd_val       = 32'h0;
    if (sel_inh) rd_val = {29'h0, inh_ir_q, 1'b0, inh_cy_q};
    else if (sel_cyc || sel_ins) rd_val = half_old;
    wr_ok  = accept & regs_req_is_wr & dec_hit & ~dec_ro;
    wr_cyc = wr_ok & sel_cyc;
    wr_ins = wr_ok & sel_ins;
    wr_inh = wr_ok & sel_inh;
  end

  // Access FSM: register the response at accept, drop it one cycle later.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q      <= ST_IDLE;
      stall_q      <= 1'b0;
      regs_rd_ack  <= 1'b0;
      regs_rd_err  <= 1'b0;
      regs_rd_data <= 32'h0;
      regs_wr_ack  <= 1'b0;
      regs_wr_err  <= 1'b0;
    end else begin
      regs_rd_ack  <= 1'b0;
      regs_rd_err  <= 1'b0;
      regs_rd_data <= 32'h0;
      regs_wr_ack  <= 1'b0;
      regs_wr_err  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RESP;
            stall_q <= 1'b1;
            if (regs_req_is_wr) begin
              regs_wr_ack <= 1'b1;
              regs_wr_err <= ~dec_hit | dec_ro;
            end else begin
              regs_rd_ack  <= 1'b1;
              regs_rd_err  <= ~dec_hit;
              regs_rd_data <= dec_hit ? rd_val : 32'h0;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // Counters: a write on an edge replaces that edge's increment.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inh_cy_q   <= 1'b0;
      inh_ir_q   <= 1'b0;
    end else begin
      if (wr_cyc)         mcycle_q <= wr_ext[CNT_WIDTH-1:0];
      else if (!inh_cy_q) mcycle_q <= mcycle_q + CNT_ONE;

      if (wr_ins)                    minstret_q <= wr_ext[CNT_WIDTH-1:0];
      else if (retire && !inh_ir_q)  minstret_q <= minstret_q + CNT_ONE;

      if (wr_inh) begin
        inh_cy_q <= (inh_cy_q & ~regs_wr_biten[0]) | (regs_wr_data[0] & regs_wr_biten[0]);
        inh_ir_q <= (inh_ir_q & ~regs_wr_biten[2]) | (regs_wr_data[2] & regs_wr_biten[2]);
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_counters.sv
// Directed bench for hsv_core_ctrlstatus_counters: reset values, read latency,
// wrap, inhibit, bit-enable merge, decode errors, back-to-back and reset mid-access.
module tb_hsv_core_ctrlstatus_counters;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        retire;
  logic        regs_req;
  logic        regs_req_is_wr;
  logic [15:0] regs_addr;
  logic [31:0] regs_wr_data;
  logic [31:0] regs_wr_biten;
  logic        regs_req_stall_rd;
  logic        regs_req_stall_wr;
  logic        regs_rd_ack;
  logic        regs_rd_err;
  logic [31:0] regs_rd_data;
  logic        regs_wr_ack;
  logic        regs_wr_err;

  int n_checks = 0;
  int n_errors = 0;

  hsv_core_ctrlstatus_counters #(.CNT_WIDTH(64), .HAS_INHIBIT(1'b1)) dut (
    .clk_core          (clk_core),
    .rst_core_n        (rst_core_n),
    .retire            (retire),
    .regs_req          (regs_req),
    .regs_req_is_wr    (regs_req_is_wr),
    .regs_addr         (regs_addr),
    .regs_wr_data      (regs_wr_data),
    .regs_wr_biten     (regs_wr_biten),
    .regs_req_stall_rd (regs_req_stall_rd),
    .regs_req_stall_wr (regs_req_stall_wr),
    .regs_rd_ack       (regs_rd_ack),
    .regs_rd_err       (regs_rd_err),
    .regs_rd_data      (regs_rd_data),
    .regs_wr_ack       (regs_wr_ack),
    .regs_wr_err       (regs_wr_err)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access; waits (bounded) for the matching ack, then one more cycle back to idle.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [31:0] be, input bit ret,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic stall_both, output logic other_ack);
    regs_req       = 1'b1;
    regs_req_is_wr = wr;
    regs_addr      = addr;
    regs_wr_data   = data;
    regs_wr_biten  = be;
    retire         = ret;
    tick();
    regs_req = 1'b0;
    retire   = 1'b0;
    lat = 1;
    while (!(wr ? regs_wr_ack : regs_rd_ack) && lat < 4) begin
      tick();
      lat++;
    end
    rdata      = regs_rd_data;
    err        = wr ? regs_wr_err : regs_rd_err;
    stall_both = regs_req_stall_rd & regs_req_stall_wr;
    other_ack  = wr ? regs_rd_ack : regs_wr_ack;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [31:0] exp_data,
                        input logic exp_err);
    logic [31:0] d;
    logic e, s, o;
    int l;
    access(1'b0, addr, 32'h0, 32'h0, 1'b0, d, e, l, s, o);
    check({tag, "_lat"}, 64'(l), 64'd1);
    check({tag, "_err"}, 64'(e), 64'(exp_err));
    check({tag, "_data"}, 64'(d), 64'(exp_data));
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] addr, input logic [31:0] data,
                        input logic [31:0] be, input bit ret, input logic exp_err);
    logic [31:0] d;
    logic e, s, o;
    int l;
    access(1'b1, addr, data, be, ret, d, e, l, s, o);
    check({tag, "_lat"}, 64'(l), 64'd1);
    check({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] d;
    logic e, s, o;
    int l;
    int acks;

    rst_core_n     = 1'b0;
    retire         = 1'b0;
    regs_req       = 1'b0;
    regs_req_is_wr = 1'b0;
    regs_addr      = 16'h0;
    regs_wr_data   = 32'h0;
    regs_wr_biten  = 32'h0;
    repeat (3) tick();
    check("rst_rd_ack", 64'(regs_rd_ack), 64'd0);
    check("rst_wr_ack", 64'(regs_wr_ack), 64'd0);
    check("rst_stall_rd", 64'(regs_req_stall_rd), 64'd0);
    check("rst_stall_wr", 64'(regs_req_stall_wr), 64'd0);
    check("rst_rd_data", 64'(regs_rd_data), 64'd0);

    // Ten counting edges, then the read samples mcycle=10 at its accept edge.
    rst_core_n = 1'b1;
    repeat (10) tick();
    access(1'b0, 16'hB000, 32'h0, 32'h0, 1'b0, d, e, l, s, o);
    check("first_rd_lat", 64'(l), 64'd1);
    check("first_rd_data", 64'(d), 64'd10);
    check("first_rd_err", 64'(e), 64'd0);
    check("first_rd_stall", 64'(s), 64'd1);
    check("first_rd_no_wr_ack", 64'(o), 64'd0);
    rd_chk("minstret_rst", 16'hB020, 32'h0, 1'b0);

    // Wrap: hi=all ones, lo=FFFFFFFE -> all ones one edge later, zero the next.
    wr_chk("wr_mcycle_hi", 16'hB800, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    access(1'b1, 16'hB000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, d, e, l, s, o);
    check("wr_mcycle_lo_err", 64'(e), 64'd0);
    check("wr_no_rd_ack", 64'(o), 64'd0);
    rd_chk("wrap_lo_allones", 16'hB000, 32'hFFFF_FFFF, 1'b0);
    rd_chk("wrap_hi_zero", 16'hB800, 32'h0, 1'b0);
    rd_chk("wrap_lo_after", 16'hB000, 32'h3, 1'b0);

    // mcountinhibit: only bits 0 and 2 exist; CY inhibit freezes mcycle.
    wr_chk("wr_inh_all", 16'h3200, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd_chk("rd_inh_all", 16'h3200, 32'h5, 1'b0);
    wr_chk("wr_mcycle_frozen", 16'hB000, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (3) tick();
    rd_chk("mcycle_frozen", 16'hB000, 32'h0000_0100, 1'b0);
    rd_chk("mcycle_frozen_hi", 16'hB800, 32'h0, 1'b0);

    // IR inhibit only, then retires are ignored.
    wr_chk("wr_inh_ir", 16'h3200, 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr_chk("wr_minstret_lo", 16'hB020, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wr_chk("wr_minstret_hi", 16'hB820, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    retire = 1'b1;
    repeat (5) tick();
    retire = 1'b0;
    rd_chk("minstret_inhibited", 16'hB020, 32'h1122_3344, 1'b0);
    rd_chk("instret_alias", 16'hC020, 32'h1122_3344, 1'b0);

    wr_chk("wr_inh_clr", 16'h3200, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    rd_chk("minstret_plus3", 16'hB020, 32'h1122_3347, 1'b0);

    // Write with a retire on the same edge: the write value wins.
    wr_chk("wr_minstret_ret", 16'hB020, 32'h1122_3344, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd_chk("minstret_write_wins", 16'hB020, 32'h1122_3344, 1'b0);
    wr_chk("wr_biten", 16'hB020, 32'hAABB_CCDD, 32'h0000_FF00, 1'b0, 1'b0);
    rd_chk("minstret_biten", 16'hB020, 32'h1122_CC44, 1'b0);
    rd_chk("minstret_hi_kept", 16'hB820, 32'h0, 1'b0);

    // Decode errors.
    wr_chk("wr_alias_err", 16'hC000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b1);
    rd_chk("rd_unmapped", 16'h1230, 32'h0, 1'b1);
    rd_chk("rd_low_nibble", 16'hB001, 32'h0, 1'b1);
    wr_chk("wr_low_nibble", 16'hB021, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    rd_chk("minstret_no_change", 16'hB020, 32'h1122_CC44, 1'b0);
    rd_chk("rd_alias_ok", 16'hC820, 32'h0, 1'b0);

    // Back-to-back: request held high, second accepted two edges after the first.
    regs_req       = 1'b1;
    regs_req_is_wr = 1'b0;
    regs_addr      = 16'hB020;
    tick();
    check("b2b_ack1", 64'(regs_rd_ack), 64'd1);
    check("b2b_stall1", 64'(regs_req_stall_rd), 64'd1);
    tick();
    check("b2b_gap_ack", 64'(regs_rd_ack), 64'd0);
    check("b2b_gap_stall", 64'(regs_req_stall_rd), 64'd0);
    tick();
    check("b2b_ack2", 64'(regs_rd_ack), 64'd1);
    check("b2b_data2", 64'(regs_rd_data), 64'h1122_CC44);
    regs_req = 1'b0;
    tick();

    // Reset while a response is pending: it is dropped and never reappears.
    regs_req  = 1'b1;
    regs_addr = 16'hB000;
    tick();
    regs_req = 1'b0;
    check("midrst_ack_before", 64'(regs_rd_ack), 64'd1);
    #2 rst_core_n = 1'b0;
    #1;
    check("midrst_ack_cleared", 64'(regs_rd_ack), 64'd0);
    check("midrst_stall_cleared", 64'(regs_req_stall_wr), 64'd0);
    tick();
    tick();
    rst_core_n = 1'b1;
    acks = 0;
    repeat (4) begin
      tick();
      if (regs_rd_ack || regs_wr_ack) acks++;
    end
    check("midrst_no_ack", 64'(acks), 64'd0);
    rd_chk("post_rst_mcycle", 16'hB000, 32'h4, 1'b0);
    rd_chk("post_rst_minstret", 16'hB020, 32'h0, 1'b0);
    rd_chk("post_rst_inh", 16'h3200, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
